// File: rtl/uart_rx_deserializer.sv
// 16x-oversampled UART receiver: 8N1 frames in, one-cycle byte strobe out.
// Define UART_RX_PARITY_EN to insert an even-parity bit check (8E1).
module uart_rx_deserializer #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            RX,
    output logic [DBIT-1:0] DOUT,
    output logic            RX_DONE,
    output logic            FRAME_ERR,
    output logic            PARITY_ERR,
    output logic [2:0]      STATE
);

    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic            rx_meta, rx_s;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [3:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] sr_reg, sr_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            par_reg, par_next;
    logic            perr_next;
`endif

    assign tick  = (tick_cnt == TW'(DVSR - 1));
    assign STATE = state_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            tick_cnt  <= '0;
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            sr_reg    <= '0;
            DOUT      <= '0;
            RX_DONE   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            rx_meta   <= RX;
            rx_s      <= rx_meta;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            sr_reg    <= sr_next;
            DOUT      <= dout_next;
            RX_DONE   <= done_next;
            FRAME_ERR <= ferr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_reg    <= 1'b0;
            PARITY_ERR <= 1'b0;
        end else begin
            par_reg    <= par_next;
            PARITY_ERR <= perr_next;
        end
    end
`else
    assign PARITY_ERR = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        sr_next    = sr_reg;
        dout_next  = DOUT;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_reg == 4'd7) begin
                        // A line that is high again mid start bit was a glitch.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_reg == 4'd15) begin
                        sr_next = {rx_s, sr_reg[DBIT-1:1]};
                        s_next  = '0;
                        if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_reg == 4'd15) begin
                        par_next   = ^{sr_reg, rx_s};
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_reg == 4'(SB_TICK - 1)) begin
                        if (rx_s) begin
                            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_reg) begin
                                perr_next = 1'b1;
                            end else begin
                                done_next = 1'b1;
                                dout_next = sr_reg;
                            end
`else
                            done_next = 1'b1;
                            dout_next = sr_reg;
`endif
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at DVSR=4 (64 clocks per bit).
// Honours UART_RX_PARITY_EN by sending an even-parity bit and adding parity vectors.
module tb_uart_rx_deserializer;

    localparam int BIT_CLKS = 64;

    logic       CLK, RESET, RX;
    logic [7:0] DOUT;
    logic       RX_DONE, FRAME_ERR, PARITY_ERR;
    logic [2:0] STATE;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
    logic [7:0] got_q[$];
    logic       prev_any = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_done;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;
    vec_t vecs[$];

    uart_rx_deserializer #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut (
        .CLK(CLK), .RESET(RESET), .RX(RX), .DOUT(DOUT), .RX_DONE(RX_DONE),
        .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR), .STATE(STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: counts pulses, records bytes, enforces exclusivity and one-cycle width.
    always @(negedge CLK) begin
        int nstb;
        if (!RESET) begin
            nstb = int'(RX_DONE) + int'(FRAME_ERR) + int'(PARITY_ERR);
            if (nstb != 0) begin
                check("strobe_exclusive", nstb, 1);
                check("strobe_width", int'(prev_any), 0);
            end
            prev_any = (nstb != 0);
            if (RX_DONE) begin
                done_cnt++;
                got_q.push_back(DOUT);
            end
            if (FRAME_ERR)  ferr_cnt++;
            if (PARITY_ERR) perr_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        RX = b;
        repeat (BIT_CLKS) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] exp_dout;
        logic [7:0] b2b[3];
        logic       b2b_par[3];
        int d0, f0, p0;

        vecs.push_back('{8'h37, 1'b1, 1'b1, 1, 0, 0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1, 0, 0});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 1, 0, 0});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 1, 0, 0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 1, 0, 0});
        vecs.push_back('{8'h55, 1'b0, 1'b0, 0, 1, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h37, 1'b1, 1'b1, 1, 0, 0});
        vecs.push_back('{8'h37, 1'b0, 1'b1, 0, 0, 1});
`endif

        RX = 1'b1;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_dout", int'(DOUT), 0);
        check("reset_rx_done", int'(RX_DONE), 0);
        check("reset_frame_err", int'(FRAME_ERR), 0);
        check("reset_parity_err", int'(PARITY_ERR), 0);
        check("reset_state", int'(STATE), 0);
        RESET = 1'b0;
        idle(40);
        exp_dout = 8'h00;

        foreach (vecs[i]) begin
            d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            if (!vecs[i].stop) begin
                repeat (100) @(posedge CLK);
                #1;
                check($sformatf("vec%0d_break_state", i), int'(STATE), 5);
                repeat (100) @(posedge CLK);
                #1;
                check($sformatf("vec%0d_break_hold", i), int'(STATE), 5);
            end
            idle(20);
            if (vecs[i].exp_done != 0) exp_dout = vecs[i].data;
            check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d_dout", i), int'(DOUT), int'(exp_dout));
            check($sformatf("vec%0d_state", i), int'(STATE), 0);
        end

        // Back-to-back frames with no idle gap between stop and next start.
        b2b[0] = 8'h2B; b2b_par[0] = 1'b0;
        b2b[1] = 8'h33; b2b_par[1] = 1'b0;
        b2b[2] = 8'h0D; b2b_par[2] = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) send_frame(b2b[k], b2b_par[k], 1'b1);
        idle(20);
        check("b2b_done", done_cnt - d0, 3);
        check("b2b_fifo_entries", got_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_q.size())
                check($sformatf("b2b_byte%0d", k), int'(got_q[k]), int'(b2b[k]));
        end
        check("b2b_dout", int'(DOUT), 8'h0D);

        // Short low glitch: START entered, then abandoned without strobes.
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        RX = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("glitch_start_state", int'(STATE), 1);
        repeat (10) @(posedge CLK);
        #1;
        idle(60);
        check("glitch_idle_state", int'(STATE), 0);
        check("glitch_strobes", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("glitch_dout", int'(DOUT), 8'h0D);

        // Reset in the middle of DATA for 0xA5 (LSB first: 1,0,1).
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("midreset_pre_state", int'(STATE), 2);
        #2 RESET = 1'b1;
        #1;
        check("midreset_dout", int'(DOUT), 0);
        check("midreset_state", int'(STATE), 0);
        check("midreset_rx_done", int'(RX_DONE), 0);
        check("midreset_frame_err", int'(FRAME_ERR), 0);
        RX = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        idle(150);
        check("midreset_no_done", done_cnt - d0, 0);
        send_frame(8'h41, 1'b0, 1'b1);
        idle(20);
        check("after_reset_done", done_cnt - d0, 1);
        check("after_reset_dout", int'(DOUT), 8'h41);
        check("after_reset_state", int'(STATE), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
